// File: rtl/ring_arb_pkg.sv
// rtl/ring_arb_pkg.sv - shared state encoding, defaults and width helper for the ring token arbiter
package ring_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 16;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int f_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ring_token_ptr.sv
// rtl/ring_token_ptr.sv - one-hot rotating priority token register
module ring_token_ptr
    import ring_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_load,
    input  logic [N-1:0] i_gnt,
    output logic [N-1:0] o_ptr
);

    logic [N-1:0] r_ptr;

    // Token starts at requester 0; on release it moves to the requester just after the one that held the grant.
    always_ff @(negedge CLK) begin
        if (RST) begin
            r_ptr <= N'(1);
        end else if (i_load) begin
            r_ptr <= {i_gnt[N-2:0], i_gnt[N-1]};
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/ring_token_arbiter.sv
// rtl/ring_token_arbiter.sv - round-robin token arbiter with hold limit and mandatory gap cycle
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N-1:0]          REQ,
    output logic [N-1:0]          GNT,
    output logic [f_clog2(N)-1:0] GNT_ID,
    output logic                  BUSY,
    output logic                  TIMEOUT
);

    localparam int              IW         = f_clog2(N);
    localparam int              HW         = f_clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_ONE   = HW'(1);

    // First set request at or above the token position, wrapping past the top.
    function automatic logic [N-1:0] f_circ_pick(input logic [N-1:0] req, input logic [N-1:0] ptr);
        logic [N-1:0] pick;
        logic         found;
        int           base;
        int           idx;
        pick  = '0;
        found = 1'b0;
        base  = 0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                base = i;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] f_encode(input logic [N-1:0] onehot);
        logic [IW-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                b = IW'(i);
            end
        end
        return b;
    endfunction

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] w_gnt_id_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_busy;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          w_ptr_load;
    logic [N-1:0]  w_ptr;
    logic [N-1:0]  w_pick;

    ring_token_ptr #(
        .N (N)
    ) u_ptr (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_ptr_load),
        .i_gnt  (r_gnt),
        .o_ptr  (w_ptr)
    );

    assign w_pick = f_circ_pick(REQ, w_ptr);

    // Next-state logic: arbitrate from IDLE/GAP, count and release in GRANT.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        w_ptr_load    = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (REQ != '0) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = w_pick;
                    w_gnt_id_nxt = f_encode(w_pick);
                    w_hold_nxt   = HOLD_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request wins over the hold limit, so it never counts as a timeout.
                if ((REQ & r_gnt) == '0) begin
                    w_state_nxt = ST_GAP;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_ptr_load  = 1'b1;
                end else if (r_hold == HOLD_LIMIT) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_ptr_load    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // State and output registers, reset overriding any grant in progress.
    always_ff @(negedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_hold    <= w_hold_nxt;
            r_busy    <= (w_gnt_nxt != '0);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign GNT     = r_gnt;
    assign GNT_ID  = r_gnt_id;
    assign BUSY    = r_busy;
    assign TIMEOUT = r_timeout;

endmodule

// File: doc/ring_token_arbiter.md
RING_TOKEN_ARBITER -- requirements
Module: ring_token_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (N >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum grant length in cycles (>= 2).
REQ-003 SHALL have port CLK  input  1: single clock; all state updates on the falling edge of CLK.
REQ-004 SHALL have port RST  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port REQ  input  N: per-requester request level, held high while the resource is wanted.
REQ-006 SHALL have port GNT  output  N: one-hot grant (all-zero when none), registered.
REQ-007 SHALL have port GNT_ID  output  clog2(N): binary index of the granted requester, valid while BUSY=1.
REQ-008 SHALL have port BUSY  output  1: high while any GNT bit is high.
REQ-009 SHALL have port TIMEOUT  output  1: one-cycle pulse on a forced release.

Function
REQ-010 SHALL hold a one-hot N-bit priority token PTR, rotating left with wrap (bit N-1 -> bit 0).
REQ-011 SHALL implement states IDLE, GRANT and GAP; the encoding is internal.
REQ-012 In IDLE or GAP, at a falling edge with REQ != 0, SHALL grant the first set REQ bit searched circularly from the PTR position upward, and enter GRANT.
REQ-013 SHALL have a latency of exactly one edge: REQ sampled at edge k -> GNT, GNT_ID and BUSY valid after edge k.
REQ-014 In IDLE with REQ = 0, SHALL stay in IDLE with GNT = 0; GAP with REQ = 0 SHALL go to IDLE.
REQ-015 In GRANT, SHALL increment a hold counter each edge, starting at 1 on the grant edge.
REQ-016 SHALL release the grant when REQ[GNT_ID] = 0 is sampled, or when the hold counter equals MAX_HOLD; the grant therefore lasts at most MAX_HOLD cycles.
REQ-017 On release, SHALL clear GNT and BUSY at that edge, enter GAP, and set PTR to GNT rotated left by one.
REQ-018 SHALL assert TIMEOUT for the one cycle after a release caused by the hold limit while REQ[GNT_ID] = 1; a voluntary release SHALL not assert TIMEOUT.
REQ-019 SHALL enforce exactly one cycle with GNT = 0 between consecutive grants (the GAP cycle), including a grant to the same requester.
REQ-020 SHALL ignore changes to REQ bits of non-granted requesters during GRANT; only the arbitration edge samples them.
REQ-021 SHALL never assert more than one GNT bit, and SHALL never assert GNT[i] without REQ[i] having been high at the arbitration edge.
REQ-022 Fairness: with all REQ bits held high, SHALL grant in order i, i+1, ..., wrapping, with no requester skipped.

Reset
REQ-023 With RST = 1 at a falling edge, SHALL set state = IDLE, GNT = 0, GNT_ID = 0, BUSY = 0, TIMEOUT = 0, hold counter = 0 and PTR = 1 (bit 0).
REQ-024 Reset SHALL take priority over all other events, including mid-grant: GNT drops at the reset edge and no TIMEOUT is issued.
REQ-025 After RST deasserts, SHALL arbitrate at the first falling edge with REQ != 0.

Structure
REQ-026 SHALL keep the state encodings, the default N and MAX_HOLD values, and the clog2 width function in a shared package/header, ring_arb_pkg.
REQ-027 SHALL implement PTR as a sub-module, ring_token_ptr: an N-bit one-hot rotating register with synchronous active-high reset to 1 and a load-enable taking the rotated grant.
REQ-028 SHALL implement the circular priority search and the one-hot to binary encode as combinational logic inside ring_token_arbiter.

Verification
REQ-029 Reset: RST = 1 for 2 edges with REQ = 4'b1111 -> GNT = 0, BUSY = 0 and TIMEOUT = 0 throughout; after release, first grant GNT = 4'b0001.
REQ-030 Rotation: REQ = 4'b1111, each requester drops REQ 3 cycles after its grant -> grant sequence 0001, 0010, 0100, 1000, 0001, each followed by one GAP cycle with GNT = 0.
REQ-031 Skip: PTR = 4'b0010 and REQ = 4'b1001 -> GNT = 4'b1000, GNT_ID = 3; after release, PTR = 4'b0001 and the next grant is 4'b0001.
REQ-032 Timeout: with MAX_HOLD = 16, REQ[2] held high alone -> GNT = 4'b0100 for exactly 16 cycles, TIMEOUT pulses once, one GAP cycle, then regranted 4'b0100.
REQ-033 Reset mid-grant: RST = 1 asserted on the 5th GRANT cycle -> GNT = 0 at that edge, TIMEOUT stays 0, and PTR = 4'b0001 afterwards.
REQ-034 Scoreboard, random REQ for 10k cycles -> one-hot GNT, no grant without a request, at most 16 cycles per grant, and every continuously requesting agent granted within N·(MAX_HOLD+1) cycles.
